// File: rtl/seq_booth_mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // {mq[0], q_1} recodings that touch the accumulator; 00/11 leave it alone
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/seq_booth_mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of ext_a into acc,
// then arithmetic right shift of {acc, mq, q_1}.
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH+2:0] cur,
    input  logic [WIDTH:0]     ext_a,
    output logic [2*WIDTH+2:0] nxt
);

    logic [WIDTH:0] acc;
    logic [WIDTH:0] mq;
    logic           q_1;
    logic [WIDTH:0] sum;

    assign acc = cur[2*WIDTH+2:WIDTH+2];
    assign mq  = cur[WIDTH+1:1];
    assign q_1 = cur[0];

    always_comb begin
        sum = acc;
        case ({mq[0], q_1})
            BOOTH_ADD: sum = acc + ext_a;
            BOOTH_SUB: sum = acc - ext_a;
            default:   sum = acc;
        endcase
    end

    // Shifting {sum, mq, q_1} right drops q_1; mq[0] becomes the new q_1.
    assign nxt = {sum[WIDTH], sum, mq};

endmodule

// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per transaction,
// with ready/valid on both sides. One Booth step per cycle, WIDTH+1 steps.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// BUSY  | one Booth step per cycle, cnt counts 0..WIDTH
// DONE  | product on z with out_valid high until out_ready
module seq_booth_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = 2 * WIDTH + 3;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    state_t          state;
    state_t          state_nxt;
    logic [RW-1:0]   work;
    logic [RW-1:0]   work_nxt;
    logic [CW-1:0]   cnt;
    logic [WIDTH:0]  ext_a;
    logic [WIDTH:0]  ext_a_in;
    logic [WIDTH:0]  ext_b_in;

    // One extra bit lets unsigned operands with MSB set run through the signed recoding.
    assign ext_a_in = is_signed ? {a[WIDTH-1], a} : {1'b0, a};
    assign ext_b_in = is_signed ? {b[WIDTH-1], b} : {1'b0, b};

    booth_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .cur  (work),
        .ext_a(ext_a),
        .nxt  (work_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = BUSY;
            BUSY:    if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            ext_a <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ext_a <= ext_a_in;
                        work  <= {{(WIDTH + 1){1'b0}}, ext_b_in, 1'b0};
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    work <= work_nxt;
                    cnt  <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    // Low 2*WIDTH bits of {acc, mq}; work is frozen outside BUSY so z holds in DONE.
    assign z         = work[2*WIDTH:1];

endmodule

// File: tb/tb_seq_booth_mult.sv
// Directed and random checks of seq_booth_mult at WIDTH=8 and WIDTH=16.
module tb_seq_booth_mult;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a_drv = '0;
    logic [15:0] b_drv = '0;
    logic        sgn_drv = 1'b0;
    logic        sel = 1'b0;

    logic        in_valid8, in_ready8, out_valid8;
    logic [15:0] z8;
    logic        in_valid16, in_ready16, out_valid16;
    logic [31:0] z16;

    logic        cur_ir, cur_ov;
    logic [31:0] cur_z;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign in_valid8  = iv & ~sel;
    assign in_valid16 = iv & sel;
    assign cur_ir = sel ? in_ready16 : in_ready8;
    assign cur_ov = sel ? out_valid16 : out_valid8;
    assign cur_z  = sel ? z16 : {16'h0, z8};

    seq_booth_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a_drv[7:0]), .b(b_drv[7:0]), .is_signed(sgn_drv),
        .out_valid(out_valid8), .out_ready(out_ready), .z(z8)
    );

    seq_booth_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a_drv), .b(b_drv), .is_signed(sgn_drv),
        .out_valid(out_valid16), .out_ready(out_ready), .z(z16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic w16, input logic [15:0] a,
                                             input logic [15:0] b, input logic s);
        logic [31:0] ea, eb, p;
        if (w16) begin
            ea = s ? {{16{a[15]}}, a} : {16'h0, a};
            eb = s ? {{16{b[15]}}, b} : {16'h0, b};
            p  = ea * eb;
        end else begin
            ea = s ? {{24{a[7]}}, a[7:0]} : {24'h0, a[7:0]};
            eb = s ? {{24{b[7]}}, b[7:0]} : {24'h0, b[7:0]};
            p  = (ea * eb) & 32'h0000_FFFF;
        end
        return p;
    endfunction

    // Called at a negedge with the selected DUT idle; returns at the negedge after the accept edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
        a_drv = a;
        b_drv = b;
        sgn_drv = s;
        iv = 1'b1;
        chk("ready_before_accept", {31'h0, cur_ir}, 32'd1);
        @(negedge clk);
        iv = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        logic busy_ready;
        lat = 0;
        busy_ready = 1'b0;
        while (!cur_ov && lat < 60) begin
            if (cur_ir) busy_ready = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, sel ? 32'd17 : 32'd9);
        chk({tag, "_ready_in_busy"}, {31'h0, busy_ready}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [31:0] exp);
        start_op(a, b, s);
        wait_done(tag);
        chk(tag, cur_z, exp);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {30'h0, cur_ov, cur_ir}, 32'd1);
    endtask

    initial begin
        logic        stable;
        logic [15:0] ra, rb;
        logic        rs;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready8", {31'h0, in_ready8}, 32'd1);
        chk("rst_valid8", {31'h0, out_valid8}, 32'd0);
        chk("rst_z8", {16'h0, z8}, 32'd0);
        chk("rst_ready16", {31'h0, in_ready16}, 32'd1);
        chk("rst_valid16", {31'h0, out_valid16}, 32'd0);
        chk("rst_z16", z16, 32'd0);

        sel = 1'b0;
        run_op("s8_min_sq", 16'h0080, 16'h0080, 1'b1, 32'h0000_4000);
        run_op("s8_7f_x_80", 16'h007F, 16'h0080, 1'b1, 32'h0000_C080);
        run_op("s8_m1_x_1", 16'h00FF, 16'h0001, 1'b1, 32'h0000_FFFF);
        run_op("u8_ff_sq", 16'h00FF, 16'h00FF, 1'b0, 32'h0000_FE01);
        run_op("s8_ff_sq", 16'h00FF, 16'h00FF, 1'b1, 32'h0000_0001);
        run_op("u8_zero", 16'h0000, 16'h00AB, 1'b0, 32'h0000_0000);

        // Backpressure: result must hold, extra in_valid ignored.
        out_ready = 1'b0;
        start_op(16'h0012, 16'h0034, 1'b0);
        wait_done("bp");
        chk("bp_z", cur_z, 32'h0000_03A8);
        stable = 1'b1;
        a_drv = 16'h0055;
        b_drv = 16'h0077;
        iv = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!(cur_ov && !cur_ir && cur_z == 32'h0000_03A8)) stable = 1'b0;
        end
        chk("bp_hold", {31'h0, stable}, 32'd1);
        a_drv = 16'h0002;
        b_drv = 16'h00FD;
        sgn_drv = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {30'h0, cur_ov, cur_ir}, 32'd1);
        @(negedge clk);
        iv = 1'b0;
        chk("bp_next_accept", {31'h0, cur_ir}, 32'd0);
        wait_done("bp_next");
        chk("bp_next_z", cur_z, 32'h0000_FFFA);
        @(negedge clk);

        // Reset in the middle of BUSY aborts the operation.
        start_op(16'h0033, 16'h0044, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_state", {30'h0, cur_ov, cur_ir}, 32'd1);
        chk("abort_z", cur_z, 32'd0);
        stable = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (cur_ov) stable = 1'b0;
        end
        chk("abort_no_output", {31'h0, stable}, 32'd1);
        run_op("s8_3_x_m5", 16'h0003, 16'h00FB, 1'b1, 32'h0000_FFF1);

        // Reset wins over a simultaneous in_valid.
        a_drv = 16'h0009;
        iv = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        rst = 1'b0;
        chk("rst_beats_valid", {31'h0, cur_ir}, 32'd1);

        sel = 1'b1;
        run_op("s16_min_sq", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        run_op("u16_ffff_sq", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        run_op("s16_7fff_x_8000", 16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000);

        for (int i = 0; i < 2000; i++) begin
            sel = i[0];
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            if (i < 8) begin
                ra = (i < 4) ? 16'hFFFF : 16'h8000;
                rb = (i[1]) ? 16'h8000 : 16'hFFFF;
            end
            if (!sel) begin
                ra[15:8] = 8'h00;
                rb[15:8] = 8'h00;
            end
            start_op(ra, rb, rs);
            wait_done("rand");
            chk("rand_z", cur_z, ref_prod(sel, ra, rb, rs));
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
